cpu_bus_ctrl: RTL and testbench
===============================

Name: cpu_bus_ctrl

Overview:
- M-cycle bus controller on the far side of the 16-bit address path.
- Accepts one read or write request per M-cycle from the CPU core. The request address is produced by the IDU or the register file.
- Sequences each request through four T-cycles (T1-T4) on the external memory bus and returns read data and completion status.
- Generates the phi M-cycle strobe that the core's 1 MHz logic (IDU, register file) clocks from.

Parameters:
- ADDR_WIDTH, 16 (2*DATA_WIDTH): request and bus address width.
- DATA_WIDTH, 8: data width. Takes the gate_boy_pkg value.
- TIMEOUT_CYCLES, 15: maximum T3 wait cycles before the transfer is aborted. Legal range 1..255.

Ports:
- clk  in  1  4 MHz T-cycle clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a clk rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- bus_addr  out  ADDR_WIDTH  external address
- bus_wdata  out  DATA_WIDTH  external write data
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_ack  in  1  memory ready / ack; sampled in T3 only
- bus_rdata  in  DATA_WIDTH  external read data
- phi  out  1  M-cycle strobe

Behaviour:
- All outputs are registered. During rst low, and on the first edge after release:
  - state=IDLE
  - req_ready=1
  - rsp_valid=0, rsp_err=0, rsp_rdata=8'hFF
  - bus_addr=0, bus_wdata=0, bus_rd=0, bus_wr=0
  - phi=0
  - wait counter=0
- States and transitions:
  - IDLE: req_ready=1. An accepted request latches write, addr and wdata, then goes to T1.
  - T1: bus_addr driven from the latched address; req_ready=0; phi=1. Goes to T2.
  - T2: bus_rd=!write, bus_wr=write; bus_wdata driven on writes; phi=1. Goes to T3.
  - T3: strobes held; phi=0.
    - bus_ack=1: capture bus_rdata on reads, go to T4.
    - bus_ack=0: wait counter increments and state stays in T3.
    - Wait counter reaches TIMEOUT_CYCLES with no ack: go to T4 with err set and rdata forced to 8'hFF (open-bus value).
  - T4: strobes deasserted; phi=0; rsp_valid=1 for exactly this cycle; rsp_err and rsp_rdata valid; req_ready=1.
    - Request accepted in T4: go directly to T1 (back-to-back).
    - No request: go to IDLE.
- Latency:
  - Zero-wait transfer: 4 clk cycles from the acceptance edge to the rsp_valid cycle.
  - Back-to-back throughput: one transfer per 4 clk cycles.
  - Each wait cycle adds 1 clk cycle.
- Signal rules:
  - bus_addr holds its last value in IDLE. bus_rd and bus_wr are never both 1.
  - rsp_rdata holds its value until the next completion. A write completion leaves rsp_rdata unchanged.
  - req_* inputs are ignored while req_ready=0; a late change mid-transfer has no effect.
  - Wait counter clears on every T1 entry and saturates at TIMEOUT_CYCLES.
- Reset mid-transfer: the state machine returns to IDLE immediately and strobes drop asynchronously. The in-flight request is discarded with no rsp_valid.

Optional Feature:
- Macro GB_BUS_WAIT_EN.
- Defined: T3 wait and timeout behaviour as above.
- Undefined:
  - bus_ack is ignored and T3 always lasts exactly 1 cycle; every transfer is fixed at 4 cycles.
  - Read data is captured from bus_rdata at the end of T3.
  - rsp_err is tied to 0; the wait counter and TIMEOUT_CYCLES logic are removed.

Test Plan:
- Reset, then a read at 16'hC000 with bus_ack tied 1 and bus_rdata=8'h3C -> bus_rd high in T2-T3; rsp_valid 4 cycles after acceptance; rsp_rdata=8'h3C, rsp_err=0.
- Write 8'hA5 to 16'hFF80 -> bus_wr high T2-T3, bus_wdata=8'hA5, bus_addr=16'hFF80; rsp_valid after 4 cycles; rsp_rdata unchanged.
- Three back-to-back requests with req_valid held high -> T4 of each followed directly by T1 of the next; rsp_valid pulses 4 cycles apart; phi pattern 1100 repeating.
- With GB_BUS_WAIT_EN, bus_ack delayed 3 cycles -> completion at cycle 7, data correct. bus_ack never asserted with TIMEOUT_CYCLES=15 -> completion at cycle 4+15, rsp_err=1, rsp_rdata=8'hFF.
- rst asserted during T2 of a read -> bus_rd drops without waiting for a clk edge; no rsp_valid. After release, req_ready=1 and a new read completes normally.
- Without GB_BUS_WAIT_EN, bus_ack held 0 -> transfer still completes in 4 cycles; rsp_err=0.

Source files
------------

// File: rtl/cpu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_bus_ctrl
//   M-cycle bus controller between the CPU core and the external memory bus.
//   Each accepted request is sequenced through T1..T4. The controller returns
//   read data and a completion status, and generates the phi M-cycle strobe
//   (high in T1/T2, low in T3/T4).
//
//   Optional feature macro: GB_BUS_WAIT_EN
//     defined   : T3 waits for bus_ack. After TIMEOUT_CYCLES wait cycles with
//                 no ack, the transfer completes with rsp_err=1 and
//                 rsp_rdata=all-ones (open-bus value).
//     undefined : bus_ack is ignored and T3 lasts exactly one cycle. rsp_err
//                 is always 0.
//
// Ports
//   clk        in   T-cycle clock (4 MHz)
//   rst        in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  request accepted on req_valid && req_ready at clk edge
//   req_write  in   1 = write, 0 = read
//   req_addr   in   request address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle completion pulse (T4)
//   rsp_rdata  out  read data, held until the next read/timeout completion
//   rsp_err    out  timeout flag, valid with rsp_valid
//   bus_addr   out  external address, holds its last value when idle
//   bus_wdata  out  external write data
//   bus_rd     out  read strobe (T2-T3)
//   bus_wr     out  write strobe (T2-T3)
//   bus_ack    in   memory ready, sampled in T3 only
//   bus_rdata  in   external read data
//   phi        out  M-cycle strobe
// -----------------------------------------------------------------------------
module cpu_bus_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 2 * DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_rd,
  output logic                  bus_wr,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  phi
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4
  } state_e;

  localparam logic [7:0]            TIMEOUT_C = 8'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] OPEN_BUS  = {DATA_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_rd_q, bus_rd_d;
  logic                  bus_wr_q, bus_wr_d;
  logic                  phi_q, phi_d;

  // Request latched at acceptance; later req_* changes are ignored.
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

`ifdef GB_BUS_WAIT_EN
  logic                  rsp_err_q, rsp_err_d;
  logic [7:0]            cnt_q, cnt_d;
`else
  // bus_ack and the timeout are not used in the fixed-length build.
  logic                  unused_wait_cfg;
  assign unused_wait_cfg = bus_ack | (|TIMEOUT_C);
`endif

  logic accept;
  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rd_d    = bus_rd_q;
    bus_wr_d    = bus_wr_q;
    phi_d       = phi_q;
`ifdef GB_BUS_WAIT_EN
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_T1: begin
        state_d  = S_T2;
        bus_rd_d = !wr_q;
        bus_wr_d = wr_q;
        if (wr_q) bus_wdata_d = wdata_q;
        phi_d    = 1'b1;
      end
      S_T2: begin
        state_d = S_T3;
        phi_d   = 1'b0;
      end
      S_T3: begin
`ifdef GB_BUS_WAIT_EN
        if (bus_ack || (cnt_q == TIMEOUT_C)) begin
          state_d     = S_T4;
          bus_rd_d    = 1'b0;
          bus_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          req_ready_d = 1'b1;
          // Ack wins over a timeout reached in the same cycle.
          rsp_err_d   = !bus_ack;
          if (!bus_ack)  rsp_rdata_d = OPEN_BUS;
          else if (!wr_q) rsp_rdata_d = bus_rdata;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        state_d     = S_T4;
        bus_rd_d    = 1'b0;
        bus_wr_d    = 1'b0;
        rsp_valid_d = 1'b1;
        req_ready_d = 1'b1;
        if (!wr_q) rsp_rdata_d = bus_rdata;
`endif
      end
      S_T4: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        bus_rd_d    = 1'b0;
        bus_wr_d    = 1'b0;
        phi_d       = 1'b0;
      end
    endcase

    // req_ready is only high in IDLE and T4, so acceptance always starts T1.
    if (accept) begin
      state_d     = S_T1;
      req_ready_d = 1'b0;
      bus_addr_d  = req_addr;
      phi_d       = 1'b1;
`ifdef GB_BUS_WAIT_EN
      cnt_d       = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= OPEN_BUS;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      phi_q       <= 1'b0;
`ifdef GB_BUS_WAIT_EN
      rsp_err_q   <= 1'b0;
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      phi_q       <= phi_d;
`ifdef GB_BUS_WAIT_EN
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;
  assign phi       = phi_q;
`ifdef GB_BUS_WAIT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_ctrl
//   Randomized bench for cpu_bus_ctrl. The expected behaviour is derived from
//   the transfer timeline measured from the acceptance edge:
//     cycle 1 = T1, cycle 2 = T2, cycles 3..3+n = T3 (n wait cycles),
//     cycle 4+n = T4 (completion).
//   The bench also keeps the values that are expected to persist between
//   transfers: last read data, bus address and write data.
// -----------------------------------------------------------------------------
module tb_cpu_bus_ctrl;

`ifdef GB_BUS_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int TO    = 15;
  localparam int NEVER = 1000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        phi;

  cpu_bus_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .phi      (phi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Values expected to persist across transfers.
  logic [7:0]  exp_rdata;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    exp_rdata = 8'hFF;
    exp_addr  = 16'h0000;
    exp_wdata = 8'h00;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_val({tag, "_req_ready"}, req_ready, 1'b1);
    check_val({tag, "_phi"},       phi,       1'b0);
    check_val({tag, "_bus_rd"},    bus_rd,    1'b0);
    check_val({tag, "_bus_wr"},    bus_wr,    1'b0);
    check_val({tag, "_bus_addr"},  bus_addr,  exp_addr);
    check_val({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
  endtask

  // Called with req_ready expected high (idle or T4), #1 after a clk edge.
  // Returns #1 into the T4 cycle of this transfer.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                      input int dly, input logic [7:0] rd);
    int n;
    bit err;
    n   = WAIT_EN ? ((dly > TO) ? TO : dly) : 0;
    err = WAIT_EN && (dly > TO);
    check_val("pre_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    // T1: request fields are scrambled; the DUT must use the latched ones.
    req_valid = $urandom_range(0, 1);
    req_write = $urandom_range(0, 1);
    req_addr  = 16'($urandom);
    req_wdata = 8'($urandom);
    bus_ack   = $urandom_range(0, 1);
    bus_rdata = 8'($urandom);
    exp_addr  = addr;
    check_val("t1_phi",       phi,       1'b1);
    check_val("t1_req_ready", req_ready, 1'b0);
    check_val("t1_bus_addr",  bus_addr,  addr);
    check_val("t1_bus_rd",    bus_rd,    1'b0);
    check_val("t1_bus_wr",    bus_wr,    1'b0);
    check_val("t1_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    // T2
    if (wr) exp_wdata = wd;
    bus_ack = $urandom_range(0, 1);
    check_val("t2_phi",       phi,       1'b1);
    check_val("t2_bus_rd",    bus_rd,    !wr);
    check_val("t2_bus_wr",    bus_wr,    wr);
    check_val("t2_bus_wdata", bus_wdata, exp_wdata);
    check_val("t2_bus_addr",  bus_addr,  addr);
    for (int w = 0; w <= n; w++) begin
      @(posedge clk); #1;
      // T3 wait cycle w
      bus_ack   = WAIT_EN ? (w == dly) : 1'($urandom_range(0, 1));
      bus_rdata = (w == n) ? rd : 8'($urandom);
      check_val("t3_phi",       phi,       1'b0);
      check_val("t3_bus_rd",    bus_rd,    !wr);
      check_val("t3_bus_wr",    bus_wr,    wr);
      check_val("t3_rsp_valid", rsp_valid, 1'b0);
      check_val("t3_req_ready", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    // T4
    bus_ack = 1'b0;
    if (err)     exp_rdata = 8'hFF;
    else if (!wr) exp_rdata = rd;
    check_val("t4_rsp_valid", rsp_valid, 1'b1);
    check_val("t4_rsp_err",   rsp_err,   err);
    check_val("t4_rsp_rdata", rsp_rdata, exp_rdata);
    check_val("t4_bus_rd",    bus_rd,    1'b0);
    check_val("t4_bus_wr",    bus_wr,    1'b0);
    check_val("t4_phi",       phi,       1'b0);
    check_val("t4_req_ready", req_ready, 1'b1);
    check_val("t4_bus_addr",  bus_addr,  addr);
  endtask

  task automatic idle(input int k);
    req_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      check_quiet("idle");
    end
  endtask

  task automatic rand_xfer();
    logic        wr;
    int          dly;
    wr  = $urandom_range(0, 1);
    dly = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 5));
    xfer(wr, 16'($urandom), 8'($urandom), dly, 8'($urandom));
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    model_reset();

    // Reset values, during reset and on the first edge after release.
    @(posedge clk); #1;
    check_quiet("rst");
    check_val("rst_rsp_err", rsp_err, 1'b0);
    rst = 1'b1;
    idle(1);

    // Read at C000 with immediate ack.
    xfer(1'b0, 16'hC000, 8'h00, 0, 8'h3C);
    idle(2);
    // Write A5 to FF80; rsp_rdata must keep 3C.
    xfer(1'b1, 16'hFF80, 8'hA5, 0, 8'h77);
    idle(1);
    // Three back-to-back transfers.
    xfer(1'b0, 16'h1234, 8'h00, 0, 8'h11);
    xfer(1'b1, 16'h2345, 8'h5A, 0, 8'h22);
    xfer(1'b0, 16'h3456, 8'h00, 0, 8'h33);
    idle(1);
    // Ack delayed by 3 cycles, then no ack at all.
    xfer(1'b0, 16'h8000, 8'h00, 3, 8'hC3);
    idle(1);
    xfer(1'b0, 16'h8001, 8'h00, NEVER, 8'h44);
    idle(1);

    // Reset during T2 of a read: strobe drops without a clk edge.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'hBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_val("mid_t2_bus_rd", bus_rd, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_quiet("mid_rst");
    @(posedge clk); #1;
    check_quiet("mid_rst_hold");
    rst = 1'b1;
    idle(2);
    xfer(1'b0, 16'hC001, 8'h00, 1, 8'h5C);
    idle(1);

    // Randomized traffic with random gaps and back-to-back runs.
    for (int t = 0; t < 40; t++) begin
      rand_xfer();
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
